pc_sequencer: RTL

Parametrised next-generation program counter for the CPU fetch stage.
- Adds the following on top of plain advance/jump: reset vector, trap entry, mret return, misaligned-target detection and a circular return-address stack (RAS) for call/return hints.
- Sits between the control unit (jump/trap/mret requests) and instruction fetch (o_PC).

---
 rtl/pc_sequencer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program counter for the CPU fetch stage. It sits between the control unit,
// which raises jump, trap and mret requests, and instruction fetch, which
// consumes o_PC. Beyond plain advance and jump it provides:
//   - a reset vector,
//   - trap entry and mret return,
//   - detection of misaligned jump targets,
//   - a circular return-address stack (RAS) that predicts return addresses.
//
// Optional feature, selected by the macro PC_SEQUENCER_INSTRET_EN:
//   defined   : o_instret counts accepted retirements (mret, taken aligned
//               jump, sequential advance) and wraps at 2^64.
//   undefined : no counter is built and o_instret is tied to 0.
//
// Parameters
//   XLEN          PC and address width in bits.
//   RESET_VECTOR  PC loaded on reset. Its low 2 bits must be 0.
//   RAS_DEPTH     number of RAS entries. Power of two, 2..16.
//
// Ports
//   i_clk            clock; all state updates on the rising edge
//   i_rst            synchronous active-high reset; overrides every input
//   i_load_PC        retire strobe; qualifies jump, mret and advance
//   i_jump_DV        jump or branch taken
//   i_jump_address   jump target
//   i_trap           trap request; acts even when i_load_PC is low
//   i_trap_vector    trap handler base (mtvec); low 2 bits ignored
//   i_mret           return from trap
//   i_mepc           trap return address; low 2 bits ignored
//   i_call           current jump is a call (push PC+4)
//   i_ret            current jump is a return (pop)
//   o_PC             current PC
//   o_PC_prev        PC before the last update
//   o_misaligned     one-cycle pulse: a taken jump target was not word aligned
//   o_bad_addr       last misaligned target; held until the next one or reset
//   o_ras_top        predicted return address; 0 when the RAS is empty
//   o_ras_valid      RAS is non-empty
//   o_ras_overflow   sticky: a push overwrote the oldest entry
//   o_instret        retired instruction count (0 unless the macro is defined)
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load_PC,
    input  logic            i_jump_DV,
    input  logic [XLEN-1:0] i_jump_address,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vector,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_call,
    input  logic            i_ret,
    output logic [XLEN-1:0] o_PC,
    output logic [XLEN-1:0] o_PC_prev,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_bad_addr,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_valid,
    output logic            o_ras_overflow,
    output logic [63:0]     o_instret
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [XLEN-1:0]  PC_INCR    = XLEN'(4);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    // What happens to the PC on this edge. The list is in priority order.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_TRAP,
        SEL_MRET,
        SEL_JUMP,
        SEL_MISALIGN,
        SEL_ADVANCE
    } pc_sel_e;

    pc_sel_e pc_sel;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
    logic             misaligned_q, misaligned_d;
    logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
    logic [XLEN-1:0]  pc_plus4;

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic             ras_ovf_q, ras_ovf_d;
    logic [XLEN-1:0]  ras_top_q, ras_top_d;

    assign pc_plus4 = pc_q + PC_INCR;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_sel = SEL_HOLD;
        if (i_trap) begin
            pc_sel = SEL_TRAP;
        end else if (i_load_PC) begin
            if (i_mret) begin
                pc_sel = SEL_MRET;
            end else if (i_jump_DV) begin
                pc_sel = (i_jump_address[1:0] == 2'b00) ? SEL_JUMP : SEL_MISALIGN;
            end else begin
                pc_sel = SEL_ADVANCE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next PC, previous PC and misalignment reporting
    // ------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        pc_prev_d    = pc_prev_q;
        misaligned_d = 1'b0;
        bad_addr_d   = bad_addr_q;
        case (pc_sel)
            SEL_TRAP: begin
                pc_d      = i_trap_vector & ALIGN_MASK;
                pc_prev_d = pc_q;
            end
            SEL_MRET: begin
                pc_d      = i_mepc & ALIGN_MASK;
                pc_prev_d = pc_q;
            end
            SEL_JUMP: begin
                pc_d      = i_jump_address;
                pc_prev_d = pc_q;
            end
            SEL_MISALIGN: begin
                // The PC stays put so fetch does not chase a bad target.
                misaligned_d = 1'b1;
                bad_addr_d   = i_jump_address;
            end
            SEL_ADVANCE: begin
                pc_d      = pc_plus4;
                pc_prev_d = pc_q;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Return-address stack
    //
    // ras_ptr_q addresses the current top entry and ras_cnt_q counts the
    // live entries. A push moves the pointer up one slot, wrapping, so that
    // once the stack is full the next push lands on the oldest entry.
    // Call/return hints are honoured only on a taken, aligned jump.
    // ------------------------------------------------------------------
    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_ovf_d = ras_ovf_q;
        if (pc_sel == SEL_JUMP) begin
            if (i_call && i_ret) begin
                // Tail call through a return: swap the top, net depth unchanged.
                ras_d[ras_ptr_q] = pc_plus4;
                if (ras_cnt_q == '0) begin
                    ras_cnt_d = CNT_W'(1);
                end
            end else if (i_call) begin
                ras_ptr_d        = ras_ptr_q + PTR_W'(1);
                ras_d[ras_ptr_d] = pc_plus4;
                if (ras_cnt_q == CNT_FULL) begin
                    ras_ovf_d = 1'b1;
                end else begin
                    ras_cnt_d = ras_cnt_q + CNT_W'(1);
                end
            end else if (i_ret && (ras_cnt_q != '0)) begin
                ras_ptr_d = ras_ptr_q - PTR_W'(1);
                ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end
        end
        // The top is registered from the next state so o_ras_top comes
        // straight from a flop rather than through the read mux.
        ras_top_d = (ras_cnt_d == '0) ? '0 : ras_d[ras_ptr_d];
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q         <= RESET_VECTOR;
            pc_prev_q    <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            bad_addr_q   <= '0;
            ras_ptr_q    <= '0;
            ras_cnt_q    <= '0;
            ras_ovf_q    <= 1'b0;
            ras_top_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            pc_prev_q    <= pc_prev_d;
            misaligned_q <= misaligned_d;
            bad_addr_q   <= bad_addr_d;
            ras_ptr_q    <= ras_ptr_d;
            ras_cnt_q    <= ras_cnt_d;
            ras_ovf_q    <= ras_ovf_d;
            ras_top_q    <= ras_top_d;
        end
    end

    // NOTE: the RAS storage has no reset. An entry is only ever read after a
    // push has written it, and an empty stack reports 0 through ras_top_q, so
    // clearing the array would only add reset fan-out.
    always_ff @(posedge i_clk) begin
        ras_q <= ras_d;
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef PC_SEQUENCER_INSTRET_EN
    logic        retire;
    logic [63:0] instret_q, instret_d;

    // Traps and misaligned jumps do not retire an instruction.
    assign retire = (pc_sel == SEL_MRET) || (pc_sel == SEL_JUMP) ||
                    (pc_sel == SEL_ADVANCE);

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign o_instret = instret_q;
`else
    assign o_instret = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs: all driven straight from flops
    // ------------------------------------------------------------------
    assign o_PC           = pc_q;
    assign o_PC_prev      = pc_prev_q;
    assign o_misaligned   = misaligned_q;
    assign o_bad_addr     = bad_addr_q;
    assign o_ras_top      = ras_top_q;
    assign o_ras_valid    = (ras_cnt_q != '0);
    assign o_ras_overflow = ras_ovf_q;

endmodule
